// File: rtl/two_reg_fifo.sv
// two_reg_fifo: two-entry register FIFO with show-ahead head word, used as an
// elastic buffer between ring pipeline stages.
module two_reg_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iWrEn,
    input  logic [WIDTH-1:0] iWrDat,
    input  logic             iRdEn,
    output logic             oFul,
    output logic             oEmpty,
    output logic [1:0]       oDatVld,
    output logic [WIDTH-1:0] oRdDat
);
    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic             push, pop;

    always_comb begin
        push    = iWrEn && !oFul;
        pop     = iRdEn && !oEmpty;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (count_q == 2'd0 && push) begin
            head_d  = iWrDat;
            count_d = 2'd1;
        end else if (count_q == 2'd1 && push && pop) begin
            head_d  = iWrDat;
        end else if (count_q == 2'd1 && push) begin
            tail_d  = iWrDat;
            count_d = 2'd2;
        end else if (count_q == 2'd1 && pop) begin
            count_d = 2'd0;
        end else if (count_q == 2'd2 && pop) begin
            head_d  = tail_q;
            count_d = 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign oEmpty  = count_q == 2'd0;
    assign oFul    = count_q == 2'd2;
    assign oDatVld = {count_q == 2'd2, count_q != 2'd0};
    assign oRdDat  = oEmpty ? '0 : head_q;
endmodule

// File: tb/tb_two_reg_fifo.sv
// tb_two_reg_fifo: queue-model checked bench for two_reg_fifo with directed
// scenarios and a randomized push/pop run.
module tb_two_reg_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iWrEn = 1'b0;
    logic [7:0] iWrDat = 8'h00;
    logic       iRdEn = 1'b0;
    logic       oFul, oEmpty;
    logic [1:0] oDatVld;
    logic [7:0] oRdDat;
    int         total = 0;
    int         bad = 0;
    logic [7:0] q[$];

    two_reg_fifo #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .iWrEn(iWrEn), .iWrDat(iWrDat), .iRdEn(iRdEn),
        .oFul(oFul), .oEmpty(oEmpty), .oDatVld(oDatVld), .oRdDat(oRdDat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of at most two words, flags taken before the edge.
    always @(posedge clk or posedge rst) begin
        if (rst) q.delete();
        else begin
            automatic bit can_push = iWrEn && q.size() < 2;
            automatic bit can_pop  = iRdEn && q.size() > 0;
            if (can_pop) void'(q.pop_front());
            if (can_push) q.push_back(iWrDat);
        end
    end

    always @(negedge clk) begin
        chk("empty", {31'd0, oEmpty}, {31'd0, q.size() == 0});
        chk("full", {31'd0, oFul}, {31'd0, q.size() == 2});
        chk("datvld", {30'd0, oDatVld}, {30'd0, q.size() == 2, q.size() > 0});
        chk("rddat", {24'd0, oRdDat}, {24'd0, q.size() > 0 ? q[0] : 8'h00});
    end

    task automatic step(input logic wr, input logic [7:0] d, input logic rd);
        iWrEn = wr;
        iWrDat = d;
        iRdEn = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [1:0] dv, input logic [7:0] rd);
        chk({name, "_dv"}, {30'd0, oDatVld}, {30'd0, dv});
        chk({name, "_rd"}, {24'd0, oRdDat}, {24'd0, rd});
        chk({name, "_flags"}, {30'd0, oFul, oEmpty}, {30'd0, dv == 2'b11, dv == 2'b00});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        lit("reset", 2'b00, 8'h00);
        step(1, 8'h11, 0); lit("fill1", 2'b01, 8'h11);
        step(1, 8'h22, 0); lit("fill2", 2'b11, 8'h11);
        repeat (3) step(1, 8'h33, 0);
        lit("overflow", 2'b11, 8'h11);
        step(0, 8'h00, 1); lit("drain1", 2'b01, 8'h22);
        step(0, 8'h00, 1); lit("drain2", 2'b00, 8'h00);
        repeat (3) step(0, 8'h00, 1);
        lit("underflow", 2'b00, 8'h00);
        step(1, 8'h44, 0); lit("after_uf", 2'b01, 8'h44);
        step(0, 8'h00, 1);
        step(1, 8'h01, 0);
        for (int d = 2; d <= 10; d++) begin
            step(1, d[7:0], 1);
            lit("stream", 2'b01, d[7:0]);
        end
        step(0, 8'h00, 1); lit("stream_end", 2'b00, 8'h00);
        step(1, 8'hA0, 0);
        step(1, 8'hB0, 0);
        step(1, 8'hC0, 1); lit("full_pushpop", 2'b01, 8'hB0);
        step(0, 8'h00, 1); lit("c0_dropped", 2'b00, 8'h00);
        step(1, 8'h05, 0);
        step(1, 8'h06, 0);
        iWrEn = 1'b0;
        #2 rst = 1'b1;
        #1 lit("async_rst", 2'b00, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        step(0, 8'h00, 1); lit("post_rst_pop", 2'b00, 8'h00);
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        step(0, 8'h00, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/two_reg_fifo.md
# two_reg_fifo

Two-entry, register-based, first-word-fall-through FIFO (`TwoRegFifo`) for the PtRingV1 network-on-chip. It is used as a small elastic buffer between ring pipeline stages. It stores up to two `WIDTH`-bit words in flip-flops. It exposes full/empty flags, a per-slot valid vector and the head word directly on its read port.

## Interface
- `WIDTH`, default 8: data word width in bits; must be ≥ 1.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `iWrEn`  in  1  push request; sampled on rising `clk`.
- `iWrDat`  in  WIDTH  push data; captured when a push is accepted.
- `iRdEn`  in  1  pop request; removes the head word when accepted.
- `oFul`  out  1  high when 2 words are stored.
- `oEmpty`  out  1  high when 0 words are stored.
- `oDatVld`  out  2  slot valid, thermometer-coded: `[0]` = head slot valid (count ≥ 1), `[1]` = second slot valid (count == 2).
- `oRdDat`  out  WIDTH  head word (show-ahead); all zeros when empty.

## Operation
- Storage is two registers, `head` (slot 0) and `tail` (slot 1), plus a 2-bit occupancy count of 0, 1 or 2. Count values of 3 are unreachable.
- Accept rules:
  - A push is accepted iff `iWrEn && !oFul`. A push while full is silently dropped; no state changes.
  - A pop is accepted iff `iRdEn && !oEmpty`. A pop while empty is silently ignored.
  - Acceptance uses the flags as they are at the start of the cycle. There is no write-through-when-full and no read-bypass-when-empty.
- Next-state per count and accepted operations:
  - Count 0, push: `head` ← `iWrDat`; count becomes 1.
  - Count 1, push only: `tail` ← `iWrDat`; count becomes 2.
  - Count 1, pop only: count becomes 0.
  - Count 1, push and pop: `head` ← `iWrDat`; count stays 1.
  - Count 2, pop: `head` ← `tail`; count becomes 1. Any simultaneous push is dropped because the FIFO is full.
  - No accepted operation: registers and count hold.
- Outputs are decoded from the count:
  - `oEmpty` = (count == 0).
  - `oFul` = (count == 2).
  - `oDatVld` = {count == 2, count ≥ 1}.
- `oRdDat` = `head` when count ≥ 1, otherwise 0.
- Data ordering is strictly FIFO. No data is corrupted on dropped operations.
- Reset (async, any time, including mid-operation):
  - count, `head` and `tail` clear to 0.
  - Resulting outputs: `oEmpty`=1, `oFul`=0, `oDatVld`=2'b00, `oRdDat`=0.
  - Operation resumes on the first rising edge after `rst` deasserts.

## Timing
- All outputs are functions of registered state only. There is no combinational path from `iWrEn`, `iRdEn` or `iWrDat` to any output.
- Write-to-read latency is 1 cycle. A word pushed into an empty FIFO at edge N appears on `oRdDat`, with `oEmpty`=0, after edge N.
- A pop at edge N shows the next word, or empty, after edge N.
- Flags update on the same edge as the count. The producer may drive `iWrEn` each cycle gated by `!oFul`, and the consumer may drive `iRdEn` gated by `!oEmpty`, for full throughput.
- Sustained throughput is one push and one pop per cycle when count is 1.
- When count is 2, a push and a pop in the same cycle yield only the pop; throughput drops for that cycle.
- Reset assertion takes effect immediately, without waiting for a clock edge.

## Test plan
All scenarios use WIDTH=8.
- **Reset:** assert `rst` mid-stream with count 2 → outputs immediately `oEmpty`=1, `oFul`=0, `oDatVld`=00, `oRdDat`=0x00. After deassertion, the first pop attempt is ignored.
- **Fill and drain:**
  - Push 0x11, then 0x22 → `oDatVld` 01 then 11, `oFul`=1, `oRdDat`=0x11.
  - Pop twice → `oRdDat` 0x22, then 0x00 with `oEmpty`=1.
- **Overflow:** at full (0x11, 0x22), push 0x33 for 3 cycles → no change. Subsequent pops return 0x11, 0x22, then empty. 0x33 is never seen.
- **Underflow:** with the FIFO empty, assert `iRdEn` for 3 cycles → `oEmpty` stays 1 and `oRdDat`=0. A following push of 0x44 reads back 0x44.
- **Streaming:**
  - With count 1 (0x01), drive simultaneous push and pop on consecutive cycles with data 0x02, 0x03, …, 0x0A.
  - Required: count stays 1, and `oRdDat` steps through 0x02…0x0A one per cycle with no loss.
- **Simultaneous push and pop at full:** with count 2 (0xA0, 0xB0), push 0xC0 and pop in the same cycle → count becomes 1 and `oRdDat`=0xB0. 0xC0 is dropped.
